// File: rtl/voice_engine.sv
// voice_engine: time-multiplexed polyphonic oscillator/envelope mixer.
// One sample_tick starts a run that visits voice v in slot v, updates its
// envelope and phase, and accumulates the scaled voice term into mix_out.
// Optional feature macro: VOICE_ENGINE_OCTAVE_EN adds an octave-up
// oscillator per voice, mixed in when octave_on is high.
//
// Handshake: sample_tick is a one-cycle request accepted only in IDLE;
// mix_valid is a one-cycle strobe qualifying mix_out, which holds its value
// until the next strobe. There is no back-pressure; a tick that arrives
// while busy is dropped and recorded in the sticky overrun flag.
module voice_engine #(
    parameter int NUM_VOICES   = 8,
    parameter int AUDIO_WIDTH  = 24,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_tick,
    input  logic [1:0]                    wave_type,
    input  logic                          octave_on,
    input  logic [NUM_VOICES-1:0]         voice_on,
    input  logic [NUM_VOICES*32-1:0]      voice_incr,
    input  logic [NUM_VOICES*3-1:0]       voice_vel,
    output logic signed [AUDIO_WIDTH-1:0] mix_out,
    output logic                          mix_valid,
    output logic [NUM_VOICES-1:0]         voice_active,
    output logic                          overrun,
    output logic [1:0]                    state_dbg
);

    localparam int          SW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_VOICES - 1);
    localparam logic [16:0] ATK  = {1'b0, 16'(ATTACK_STEP)};
    localparam logic [15:0] REL  = 16'(RELEASE_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [SW-1:0]                 slot_q, slot_d;
    logic signed [AUDIO_WIDTH-1:0] acc_q, acc_d;
    logic signed [AUDIO_WIDTH-1:0] mix_out_q, mix_out_d;
    logic                          mix_valid_q, mix_valid_d;
    logic                          overrun_q, overrun_d;
    logic                          slot_en;

    logic [31:0] phase_q [NUM_VOICES];
    logic [15:0] env_q   [NUM_VOICES];

    // Per-slot datapath signals
    logic [31:0]        phase_cur, phase_d, incr_cur;
    logic [15:0]        env_cur, env_d;
    logic [16:0]        env_sum;
    logic [2:0]         vel_cur;
    logic [3:0]         vel_p1;
    logic signed [15:0] osc;
    logic signed [16:0] osc_mix;
    logic signed [33:0] env_prod;
    logic signed [16:0] scaled;
    logic signed [20:0] vel_prod;
    logic signed [16:0] voice_term;

`ifdef VOICE_ENGINE_OCTAVE_EN
    logic [31:0]        phase_oct_q [NUM_VOICES];
    logic [31:0]        phase_oct_cur, phase_oct_d;
    logic signed [15:0] osc_oct;
    logic signed [16:0] osc_sum;
`else
    logic unused_octave_on;
    assign unused_octave_on = octave_on;
`endif

    // Waveform from the top 17 phase bits (phase[31:15])
    function automatic logic signed [15:0] osc_gen(input logic [16:0] ph_hi,
                                                   input logic [1:0]  wt);
        logic signed [15:0] s;
        case (wt)
            2'b00:   s = $signed(ph_hi[16:1] ^ 16'h8000);
            2'b01:   s = ph_hi[16] ? -16'sd32767 : 16'sd32767;
            2'b10:   s = $signed((ph_hi[16] ? ~ph_hi[15:0] : ph_hi[15:0]) ^ 16'h8000);
            default: s = 16'sd0;
        endcase
        return s;
    endfunction

    // Datapath for the voice selected by the current slot
    always_comb begin
        phase_cur = phase_q[slot_q];
        env_cur   = env_q[slot_q];
        incr_cur  = voice_incr[slot_q*32 +: 32];
        vel_cur   = voice_vel[slot_q*3 +: 3];

        env_sum = {1'b0, env_cur} + ATK;
        if (voice_on[slot_q]) begin
            env_d = env_sum[16] ? 16'hFFFF : env_sum[15:0];
        end else begin
            env_d = (env_cur >= REL) ? (env_cur - REL) : 16'd0;
        end

        phase_d = phase_cur + incr_cur;
        osc     = osc_gen(phase_cur[31:15], wave_type);
`ifdef VOICE_ENGINE_OCTAVE_EN
        phase_oct_cur = phase_oct_q[slot_q];
        phase_oct_d   = phase_oct_cur + {incr_cur[30:0], 1'b0};
        osc_oct       = osc_gen(phase_oct_cur[31:15], wave_type);
        osc_sum       = 17'(osc) + 17'(osc_oct);
        osc_mix       = octave_on ? 17'(osc_sum >>> 1) : 17'(osc);
`else
        osc_mix = 17'(osc);
`endif
        env_prod   = 34'(osc_mix) * 34'($signed({1'b0, env_d}));
        scaled     = 17'(env_prod >>> 16);
        vel_p1     = {1'b0, vel_cur} + 4'd1;
        vel_prod   = 21'(scaled) * 21'($signed({1'b0, vel_p1}));
        voice_term = 17'(vel_prod >>> 3);
    end

    // Sequencer: next state, slot counter, accumulator and output register
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        acc_d       = acc_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        slot_en     = 1'b0;
        overrun_d   = overrun_q | (sample_tick && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = RUN;
                    slot_d  = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                slot_en = 1'b1;
                acc_d   = acc_q + AUDIO_WIDTH'(voice_term);
                if (slot_q == LAST) begin
                    state_d     = DONE;
                    mix_out_d   = acc_q + AUDIO_WIDTH'(voice_term);
                    mix_valid_d = 1'b1;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            acc_q       <= acc_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Per-voice phase and envelope storage, written only in the voice's slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                env_q[i]   <= '0;
`ifdef VOICE_ENGINE_OCTAVE_EN
                phase_oct_q[i] <= '0;
`endif
            end
        end else if (slot_en) begin
            phase_q[slot_q] <= phase_d;
            env_q[slot_q]   <= env_d;
`ifdef VOICE_ENGINE_OCTAVE_EN
            phase_oct_q[slot_q] <= phase_oct_d;
`endif
        end
    end

    // A voice is active while its envelope is non-zero
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_active[v] = (env_q[v] != 16'd0);
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_voice_engine.sv
// tb_voice_engine: directed checks of voice_engine with 4 voices and
// full-scale attack/release steps so envelopes jump straight to 0 or 65535.
module tb_voice_engine;

  localparam int NV = 4;
  localparam int AW = 24;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_tick = 1'b0;
  logic [1:0]           wave_type = 2'b00;
  logic                 octave_on = 1'b0;
  logic [NV-1:0]        voice_on = '0;
  logic [NV*32-1:0]     voice_incr = '0;
  logic [NV*3-1:0]      voice_vel = '0;
  logic signed [AW-1:0] mix_out;
  logic                 mix_valid;
  logic [NV-1:0]        voice_active;
  logic                 overrun;
  logic [1:0]           state_dbg;

  int checks = 0;
  int failures = 0;

  voice_engine #(
    .NUM_VOICES  (NV),
    .AUDIO_WIDTH (AW),
    .ATTACK_STEP (65535),
    .RELEASE_STEP(65535)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .wave_type   (wave_type),
    .octave_on   (octave_on),
    .voice_on    (voice_on),
    .voice_incr  (voice_incr),
    .voice_vel   (voice_vel),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .voice_active(voice_active),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_voice(input int v, input logic on, input logic [31:0] incr,
                           input logic [2:0] vel);
    voice_on[v]          = on;
    voice_incr[v*32 +: 32] = incr;
    voice_vel[v*3 +: 3]  = vel;
  endtask

  // Tick in cycle T=1 cycle of the call; loop cycle c is T+c. An optional
  // extra tick is driven in cycle T+extra_at. Window bounds the wait.
  task automatic run_tick(input int extra_at, output int lat, output int pulses,
                          output logic signed [AW-1:0] val);
    lat = -1;
    pulses = 0;
    val = '0;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 12; c++) begin
      sample_tick = (c == extra_at);
      if (mix_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          val = mix_out;
        end
      end
      @(posedge clk);
      #1;
    end
    sample_tick = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int pulses;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mix_out, mix_valid, voice_active, overrun, state_dbg} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got mix=%0d valid=%b act=%b ovr=%b st=%0d exp all 0",
               mix_out, mix_valid, voice_active, overrun, state_dbg);
    end
    rst = 1'b0;
    wave_type = 2'b01;
    set_voice(0, 1'b1, 32'h1000_0000, 3'd7);
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (voice_active !== 4'b0001) begin
      failures++;
      $display("FAIL midrun_active got=%b exp=0001", voice_active);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mix_out, mix_valid, voice_active, overrun, state_dbg} !== '0) begin
      failures++;
      $display("FAIL midrun_reset got mix=%0d valid=%b act=%b ovr=%b st=%0d exp all 0",
               mix_out, mix_valid, voice_active, overrun, state_dbg);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (mix_valid) pulses++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (pulses !== 0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL aborted_run got pulses=%0d st=%0d exp pulses=0 st=0", pulses, state_dbg);
    end
  endtask

  task automatic test_square();
    int lat, pulses;
    logic signed [AW-1:0] val;
    wave_type = 2'b01;
    set_voice(0, 1'b1, 32'h1000_0000, 3'd7);
    run_tick(0, lat, pulses, val);
    checks++;
    if (lat !== 5 || pulses !== 1) begin
      failures++;
      $display("FAIL square_timing got lat=%0d pulses=%0d exp lat=5 pulses=1", lat, pulses);
    end
    checks++;
    if (val !== 24'sd32766) begin
      failures++;
      $display("FAIL square_value got=%0d exp=32766", val);
    end
    checks++;
    if (voice_active !== 4'b0001 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL square_status got act=%b ovr=%b exp act=0001 ovr=0", voice_active, overrun);
    end
    checks++;
    if (mix_out !== 24'sd32766) begin
      failures++;
      $display("FAIL square_hold got=%0d exp=32766", mix_out);
    end
  endtask

  // phase0 = 0x10000000: triangle -> -24576, scaled by env -> -24576, vel 3 -> -12288
  // phase0 = 0x20000000: saw 0x2000^0x8000 -> -24576, vel 0 -> -3072
  task automatic test_waves();
    int lat, pulses;
    logic signed [AW-1:0] val;
    wave_type = 2'b10;
    set_voice(0, 1'b1, 32'h1000_0000, 3'd3);
    run_tick(0, lat, pulses, val);
    checks++;
    if (val !== -24'sd12288 || lat !== 5) begin
      failures++;
      $display("FAIL triangle_value got=%0d lat=%0d exp=-12288 lat=5", val, lat);
    end
    wave_type = 2'b00;
    set_voice(0, 1'b1, 32'h1000_0000, 3'd0);
    run_tick(0, lat, pulses, val);
    checks++;
    if (val !== -24'sd3072) begin
      failures++;
      $display("FAIL saw_value got=%0d exp=-3072", val);
    end
  endtask

  task automatic test_release();
    int lat, pulses;
    logic signed [AW-1:0] val;
    wave_type = 2'b01;
    set_voice(0, 1'b0, 32'h1000_0000, 3'd7);
    run_tick(0, lat, pulses, val);
    checks++;
    if (val !== 24'sd0 || lat !== 5) begin
      failures++;
      $display("FAIL release_value got=%0d lat=%0d exp=0 lat=5", val, lat);
    end
    checks++;
    if (voice_active !== 4'b0000) begin
      failures++;
      $display("FAIL release_active got=%b exp=0000", voice_active);
    end
  endtask

  // phase0 is 0x40000000 here, then 0x50000000: both in the positive square half
  task automatic test_overrun();
    int lat, pulses;
    logic signed [AW-1:0] val;
    wave_type = 2'b01;
    set_voice(0, 1'b1, 32'h1000_0000, 3'd7);
    run_tick(2, lat, pulses, val);
    checks++;
    if (lat !== 5 || pulses !== 1 || val !== 24'sd32766) begin
      failures++;
      $display("FAIL overrun_run got lat=%0d pulses=%0d val=%0d exp lat=5 pulses=1 val=32766",
               lat, pulses, val);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b exp=1", overrun);
    end
    run_tick(0, lat, pulses, val);
    checks++;
    if (overrun !== 1'b1 || val !== 24'sd32766 || pulses !== 1) begin
      failures++;
      $display("FAIL overrun_sticky got ovr=%b val=%0d pulses=%0d exp ovr=1 val=32766 pulses=1",
               overrun, val, pulses);
    end
    do_reset();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=%b exp=0", overrun);
    end
  endtask

  task automatic test_all_voices();
    int lat, pulses;
    logic signed [AW-1:0] val;
    wave_type = 2'b01;
    for (int v = 0; v < NV; v++) set_voice(v, 1'b1, 32'h0100_0000 * (v + 1), 3'd7);
    run_tick(0, lat, pulses, val);
    checks++;
    if (val !== 24'sd131064 || lat !== 5) begin
      failures++;
      $display("FAIL all_voices got=%0d lat=%0d exp=131064 lat=5", val, lat);
    end
    checks++;
    if (voice_active !== 4'b1111) begin
      failures++;
      $display("FAIL all_active got=%b exp=1111", voice_active);
    end
    for (int v = 0; v < NV; v++) set_voice(v, 1'b0, 32'h0, 3'd0);
    run_tick(0, lat, pulses, val);
    checks++;
    if (val !== 24'sd0 || voice_active !== 4'b0000) begin
      failures++;
      $display("FAIL all_release got val=%0d act=%b exp val=0 act=0000", val, voice_active);
    end
  endtask

  // First tick: phase 0 (and octave phase 0): saw -32768 in every case.
  // Second tick: main phase 0x40000000 -> -16384; with the octave oscillator
  // at 0x80000000 -> 0, mixed (-16384+0)>>>1 = -8192.
  task automatic test_octave();
    int lat, pulses;
    logic signed [AW-1:0] val;
    logic signed [AW-1:0] exp2;
`ifdef VOICE_ENGINE_OCTAVE_EN
    exp2 = -24'sd8192;
`else
    exp2 = -24'sd16384;
`endif
    do_reset();
    wave_type = 2'b00;
    octave_on = 1'b1;
    set_voice(0, 1'b1, 32'h4000_0000, 3'd7);
    run_tick(0, lat, pulses, val);
    checks++;
    if (val !== -24'sd32768) begin
      failures++;
      $display("FAIL octave_tick1 got=%0d exp=-32768", val);
    end
    run_tick(0, lat, pulses, val);
    checks++;
    if (val !== exp2) begin
      failures++;
      $display("FAIL octave_tick2 got=%0d exp=%0d", val, exp2);
    end
    wave_type = 2'b11;
    run_tick(0, lat, pulses, val);
    checks++;
    if (val !== 24'sd0 || voice_active !== 4'b0001) begin
      failures++;
      $display("FAIL silent_value got val=%0d act=%b exp val=0 act=0001", val, voice_active);
    end
    octave_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_square();
    test_waves();
    test_release();
    test_overrun();
    test_all_voices();
    test_octave();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_engine.md
VOICE_ENGINE -- requirements
Module: voice_engine

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, voice count (1..64).
REQ-002 SHALL have parameter AUDIO_WIDTH, default 24, mix output width (>=24).
REQ-003 SHALL have parameter ATTACK_STEP, default 64, envelope rise per voice slot (16-bit unsigned).
REQ-004 SHALL have parameter RELEASE_STEP, default 16, envelope fall per voice slot (16-bit unsigned).
REQ-005 SHALL have port clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port sample_tick, input, 1, one-cycle sample strobe.
REQ-008 SHALL have port wave_type, input, 2, waveform: 00 saw, 01 square, 10 triangle, 11 silent.
REQ-009 SHALL have port octave_on, input, 1, adds the octave-up oscillator.
REQ-010 SHALL have port voice_on, input, NUM_VOICES, gate per voice.
REQ-011 SHALL have port voice_incr, input, NUM_VOICES x 32, phase increment per voice.
REQ-012 SHALL have port voice_vel, input, NUM_VOICES x 3, velocity per voice.
REQ-013 SHALL have port mix_out, output, AUDIO_WIDTH signed, summed sample.
REQ-014 SHALL have port mix_valid, output, 1, one-cycle strobe marking a new mix_out.
REQ-015 SHALL have port voice_active, output, NUM_VOICES, bit v high while env[v] != 0.
REQ-016 SHALL have port overrun, output, 1, sticky: a sample_tick arrived while the engine was busy.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on sample_tick; RUN->DONE after slot NUM_VOICES-1; DONE->IDLE after one cycle.
REQ-018 SHALL process voice v in RUN slot v; for a tick in cycle T, slot v falls in cycle T+1+v.
REQ-019 SHALL register mix_out and pulse mix_valid for exactly one cycle at T+NUM_VOICES+1; mix_out holds until the next pulse.
REQ-020 SHALL, in slot v: env[v] = min(env+ATTACK_STEP, 65535) when voice_on[v]=1, else max(env-RELEASE_STEP, 0); the updated env is used in the same slot.
REQ-021 SHALL use the pre-increment phase[v] for the waveform sample, then set phase[v] += voice_incr[v] mod 2^32.
REQ-022 SHALL generate 16-bit signed osc samples as follows: saw = phase[31:16]^0x8000; square = phase[31] ? -32767 : +32767; triangle = (phase[31] ? ~phase[30:15] : phase[30:15])^0x8000; silent = 0.
REQ-023 SHALL compute voice = ((osc*env)>>>16) * (vel+1) >>> 3 as 17-bit signed, with arithmetic shifts that truncate toward negative infinity.
REQ-024 SHALL sign-extend and accumulate all NUM_VOICES voice terms from zero each sample; no saturation is needed under the limits in REQ-001/002.
REQ-025 SHALL include every voice in the sum regardless of the voice_on bit; a voice whose env is 0 contributes 0.
REQ-026 SHALL ignore a sample_tick in RUN or DONE, set overrun=1 and leave the run undisturbed; a tick in IDLE proceeds normally.
REQ-027 SHALL sample voice_on, voice_incr, voice_vel, wave_type and octave_on in each voice's own slot only.

Reset
REQ-028 SHALL force, while rst=1: state IDLE, all phases 0, all env 0, mix_out 0, mix_valid 0, voice_active 0, overrun 0.
REQ-029 SHALL abort any run in progress when rst is asserted mid-run, emit no mix_valid for it, and treat the first tick after release as a fresh sample.

Configuration
REQ-030 SHALL, with VOICE_ENGINE_OCTAVE_EN defined, keep a second phase accumulator per voice that advances by voice_incr<<1 (mod 2^32) and is reset to 0.
REQ-031 SHALL, with VOICE_ENGINE_OCTAVE_EN defined and octave_on=1, replace osc with (osc+osc_oct)>>>1 (17-bit intermediate) before the env multiply.
REQ-032 SHALL, without VOICE_ENGINE_OCTAVE_EN, omit the octave accumulators and ignore octave_on.

Verification (NUM_VOICES=4, ATTACK_STEP=65535, RELEASE_STEP=65535)
REQ-033 SHALL check reset: assert rst mid-run -> all outputs 0 and no mix_valid until the next tick.
REQ-034 SHALL check square: voice_on=0001, incr0=0x10000000, vel0=7, wave=01, tick at T -> mix_valid at T+5 with mix_out=32766.
REQ-035 SHALL check release: drop voice_on[0] and tick -> mix_out=0 and voice_active=0000.
REQ-036 SHALL check overrun: a second tick at T+2 -> overrun=1, exactly one mix_valid at T+5, and overrun stays 1 until reset.
REQ-037 SHALL check all voices: all four voices on, square, vel=7, phase 0 -> mix_out=131064.
REQ-038 SHALL check octave (macro defined): octave_on=1, saw, incr0=0x40000000 -> the second tick gives mix_out=((0x4000^0x8000 + 0x8000^0x8000 as signed)>>>1)*65535>>>16 as expected.
